// File: rtl/seq_pkg.sv
// Shared phase/fault-cause encodings and default sizing for the multicycle sequencer.
package seq_pkg;

  localparam int SEQ_STEP_WIDTH = 3;
  localparam int SEQ_MAX_STEPS  = 8;

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_FETCH_LO = 3'd1,
    PH_FETCH_HI = 3'd2,
    PH_EXEC     = 3'd3,
    PH_IRQ      = 3'd4,
    PH_FAULT    = 3'd7
  } phase_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_OVERFLOW = 2'd2
  } cause_e;

endpackage

// File: rtl/seq_step_counter.sv
// Execute/IRQ step counter: clear beats hold, hold beats increment; tc flags step==MAX_STEPS-1.
module seq_step_counter
  import seq_pkg::*;
#(
  parameter int STEP_WIDTH = SEQ_STEP_WIDTH,
  parameter int MAX_STEPS  = SEQ_MAX_STEPS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  hold,
  input  logic                  inc,
  output logic [STEP_WIDTH-1:0] count,
  output logic                  tc
);

  localparam logic [STEP_WIDTH-1:0] LAST = STEP_WIDTH'(MAX_STEPS - 1);

  logic [STEP_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !hold) begin
      count_d = count_q + STEP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Instruction sequencer: FETCH_LO -> FETCH_HI -> EXEC steps, with illegal/overflow trap.
// Optional interrupt-entry phase enabled by defining SEQ_IRQ_EN.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int STEP_WIDTH = SEQ_STEP_WIDTH,
  parameter int MAX_STEPS  = SEQ_MAX_STEPS
`ifdef SEQ_IRQ_EN
  ,
  parameter int IRQ_STEPS  = 2
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef SEQ_IRQ_EN
  input  logic                  irq,
  output logic                  irqAck,
`endif
  input  logic                  run,
  input  logic                  memReq,
  input  logic                  memReady,
  input  logic                  lastStep,
  input  logic                  illegal,
  output logic                  fetchReq,
  output logic                  instrLowWriteEn,
  output logic                  instrHighWriteEn,
  output logic [2:0]            phase,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  stall,
  output logic                  instrDone,
  output logic                  fault,
  output logic [1:0]            faultCause
);

`ifdef SEQ_IRQ_EN
  localparam logic [STEP_WIDTH-1:0] IRQ_LAST = STEP_WIDTH'(IRQ_STEPS - 1);
`endif

  phase_e state_q, state_d;
  cause_e cause_q, cause_d;

  logic                  step_clr, step_hold, step_inc, step_tc;
  logic [STEP_WIDTH-1:0] step_cnt;

  seq_step_counter #(
    .STEP_WIDTH(STEP_WIDTH),
    .MAX_STEPS (MAX_STEPS)
  ) u_step (
    .clk  (clk),
    .reset(reset),
    .clr  (step_clr),
    .hold (step_hold),
    .inc  (step_inc),
    .count(step_cnt),
    .tc   (step_tc)
  );

  // Memory handshake: a request (fetch phases, or memReq in EXEC/IRQ) completes only in a
  // cycle where memReady=1; until then the phase and step hold and stall=1. memReady with
  // no request outstanding is ignored.
  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    step_clr         = 1'b0;
    step_hold        = 1'b0;
    step_inc         = 1'b0;
    fetchReq         = 1'b0;
    instrLowWriteEn  = 1'b0;
    instrHighWriteEn = 1'b0;
    stall            = 1'b0;
    instrDone        = 1'b0;
`ifdef SEQ_IRQ_EN
    irqAck           = 1'b0;
`endif
    case (state_q)
      PH_IDLE: begin
        step_clr = 1'b1;
        if (run) state_d = PH_FETCH_LO;
      end
      PH_FETCH_LO: begin
        fetchReq = 1'b1;
        step_clr = 1'b1;
        if (memReady) begin
          instrLowWriteEn = 1'b1;
          state_d         = PH_FETCH_HI;
        end else begin
          stall = 1'b1;
        end
      end
      PH_FETCH_HI: begin
        fetchReq = 1'b1;
        step_clr = 1'b1;
        if (memReady) begin
          instrHighWriteEn = 1'b1;
          state_d          = PH_EXEC;
        end else begin
          stall = 1'b1;
        end
      end
      PH_EXEC: begin
        if ((step_cnt == '0) && illegal) begin
          state_d   = PH_FAULT;
          cause_d   = CAUSE_ILLEGAL;
          step_hold = 1'b1;
        end else if (memReq && !memReady) begin
          stall     = 1'b1;
          step_hold = 1'b1;
        end else if (lastStep) begin
          instrDone = 1'b1;
          step_clr  = 1'b1;
`ifdef SEQ_IRQ_EN
          if (irq) state_d = PH_IRQ;
          else
`endif
          if (run) state_d = PH_FETCH_LO;
          else     state_d = PH_IDLE;
        end else if (step_tc) begin
          // Trap before the counter could wrap; step stays at the limit for debug.
          state_d   = PH_FAULT;
          cause_d   = CAUSE_OVERFLOW;
          step_hold = 1'b1;
        end else begin
          step_inc = 1'b1;
        end
      end
`ifdef SEQ_IRQ_EN
      PH_IRQ: begin
        if (memReq && !memReady) begin
          stall     = 1'b1;
          step_hold = 1'b1;
        end else if (step_cnt == IRQ_LAST) begin
          irqAck   = 1'b1;
          step_clr = 1'b1;
          state_d  = PH_FETCH_LO;
        end else begin
          step_inc = 1'b1;
        end
      end
`endif
      PH_FAULT: begin
        step_hold = 1'b1;
      end
      default: begin
        state_d  = PH_IDLE;
        step_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PH_IDLE;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign phase      = state_q;
  assign step       = step_cnt;
  assign fault      = (state_q == PH_FAULT);
  assign faultCause = cause_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed vector table plus randomized instruction programs
// expanded into expected per-cycle records. Covers the SEQ_IRQ_EN build when that macro is set.
module tb_multicycle_sequencer;

  localparam int SW       = 3;
  localparam int MAXS     = 8;
  localparam int IRQ_ST   = 2;
  localparam int BW       = 12 + SW;

  typedef struct {
    bit          rst, run, req, rdy, last, ill, irq;
    bit          e_fr, e_lo, e_hi;
    logic [2:0]  e_ph;
    logic [SW-1:0] e_st;
    bit          e_stall, e_done, e_fault;
    logic [1:0]  e_cause;
    bit          e_ack;
  } vec_t;

  logic clk = 1'b0;
  logic reset, run, memReq, memReady, lastStep, illegal;
  logic fetchReq, instrLowWriteEn, instrHighWriteEn, stall, instrDone, fault;
  logic [2:0] phase;
  logic [SW-1:0] step;
  logic [1:0] faultCause;
  logic irq_ack;
`ifdef SEQ_IRQ_EN
  logic irq;
`endif

  int checks = 0;
  int errors = 0;
  int vidx   = 0;
  bit g_idle = 1'b0;
  vec_t vq[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk             (clk),
    .reset           (reset),
`ifdef SEQ_IRQ_EN
    .irq             (irq),
    .irqAck          (irq_ack),
`endif
    .run             (run),
    .memReq          (memReq),
    .memReady        (memReady),
    .lastStep        (lastStep),
    .illegal         (illegal),
    .fetchReq        (fetchReq),
    .instrLowWriteEn (instrLowWriteEn),
    .instrHighWriteEn(instrHighWriteEn),
    .phase           (phase),
    .step            (step),
    .stall           (stall),
    .instrDone       (instrDone),
    .fault           (fault),
    .faultCause      (faultCause)
  );

`ifndef SEQ_IRQ_EN
  assign irq_ack = 1'b0;
`endif

  // ---------------- record helpers ----------------
  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic vec_t mk(bit rst, bit rn, bit rq, bit rd, bit ls, bit il, bit iq,
                              bit fr, bit lo, bit hi, logic [2:0] ph, int st,
                              bit stl, bit dn, bit flt, logic [1:0] cs, bit ack);
    vec_t r;
    r.rst = rst; r.run = rn; r.req = rq; r.rdy = rd; r.last = ls; r.ill = il; r.irq = iq;
    r.e_fr = fr; r.e_lo = lo; r.e_hi = hi; r.e_ph = ph; r.e_st = SW'(st);
    r.e_stall = stl; r.e_done = dn; r.e_fault = flt; r.e_cause = cs; r.e_ack = ack;
    return r;
  endfunction

  // ---------------- driver + scoreboard compare ----------------
  task automatic apply(input vec_t r);
    logic [BW-1:0] act, exp;
    reset = r.rst; run = r.run; memReq = r.req; memReady = r.rdy;
    lastStep = r.last; illegal = r.ill;
`ifdef SEQ_IRQ_EN
    irq = r.irq;
`endif
    @(negedge clk);
    act = {fetchReq, instrLowWriteEn, instrHighWriteEn, phase, step,
           stall, instrDone, fault, faultCause, irq_ack};
    exp = {r.e_fr, r.e_lo, r.e_hi, r.e_ph, r.e_st,
           r.e_stall, r.e_done, r.e_fault, r.e_cause, r.e_ack};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d outputs[fr lo hi ph st stall done fault cause ack]: got %b expected %b",
               vidx, act, exp);
    end
    vidx++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: program -> expected cycle trace ----------------
  task automatic gen_fetch(input bit hi_byte);
    int w = $urandom_range(0, 2);
    logic [2:0] ph = hi_byte ? 3'd2 : 3'd1;
    for (int i = 0; i < w; i++)
      vq.push_back(mk(0, rnd(), rnd(), 0, rnd(), rnd(), rnd(), 1, 0, 0, ph, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, rnd(), rnd(), 1, rnd(), rnd(), rnd(), 1, !hi_byte, hi_byte, ph, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic gen_fault(input logic [1:0] cause, input int st);
    int k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++)
      vq.push_back(mk(0, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 0, 0, 0, 7, st, 0, 0, 1, cause, 0));
    vq.push_back(mk(1, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    g_idle = 1'b1;
  endtask

  task automatic gen_irq();
    for (int s = 0; s < IRQ_ST; s++) begin
      bit rq = rnd();
      int w  = rq ? $urandom_range(0, 2) : 0;
      for (int i = 0; i < w; i++)
        vq.push_back(mk(0, rnd(), 1, 0, rnd(), rnd(), rnd(), 0, 0, 0, 4, s, 1, 0, 0, 0, 0));
      vq.push_back(mk(0, rnd(), rq, rq ? 1'b1 : rnd(), rnd(), rnd(), rnd(),
                      0, 0, 0, 4, s, 0, 0, 0, 0, s == IRQ_ST - 1));
    end
  endtask

  // n execute steps; n > MAXS means lastStep never comes (overflow trap).
  task automatic gen_instr(input int n, input bit force_ill);
    if (g_idle) begin
      int k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++)
        vq.push_back(mk(0, 0, rnd(), rnd(), rnd(), rnd(), rnd(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 1, rnd(), rnd(), rnd(), rnd(), rnd(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      g_idle = 1'b0;
    end
    gen_fetch(1'b0);
    gen_fetch(1'b1);
    for (int s = 0; s < MAXS; s++) begin
      bit ls = (s == n - 1);
      bit rq = rnd();
      int w  = rq ? $urandom_range(0, 3) : 0;
      if (s == 0 && force_ill) begin
        vq.push_back(mk(0, rnd(), rnd(), rnd(), rnd(), 1, rnd(), 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
        gen_fault(2'd1, 0);
        return;
      end
      for (int i = 0; i < w; i++)
        vq.push_back(mk(0, rnd(), 1, 0, ls, (s == 0) ? 1'b0 : rnd(), rnd(),
                        0, 0, 0, 3, s, 1, 0, 0, 0, 0));
      if (ls) begin
        bit rn = ($urandom_range(0, 3) != 0);
        bit iq = 1'b0;
`ifdef SEQ_IRQ_EN
        iq = ($urandom_range(0, 2) == 0);
`endif
        vq.push_back(mk(0, rn, rq, rq ? 1'b1 : rnd(), 1, (s == 0) ? 1'b0 : rnd(), iq,
                        0, 0, 0, 3, s, 0, 1, 0, 0, 0));
        if (iq) gen_irq();
        else if (!rn) g_idle = 1'b1;
        return;
      end
      vq.push_back(mk(0, rnd(), rq, rq ? 1'b1 : rnd(), 0, (s == 0) ? 1'b0 : rnd(), rnd(),
                      0, 0, 0, 3, s, 0, 0, 0, 0, 0));
      if (s == MAXS - 1) begin
        gen_fault(2'd2, s);
        return;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t tbl[$];
    reset = 1'b1; run = 1'b0; memReq = 1'b0; memReady = 1'b0;
    lastStep = 1'b0; illegal = 1'b0;
`ifdef SEQ_IRQ_EN
    irq = 1'b0;
`endif
    // Directed table: rst run req rdy last ill irq | fr lo hi ph st stall done fault cause ack
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 1,1,0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 1,0,1,2,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 0,0,0,3,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 0,0,0,3,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,1,0,0, 0,0,0,3,2,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 1,1,0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 1,0,1,2,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 0,0,0,3,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 0,0,0,3,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 0,0,0,3,2,0,0,0,0,0));
    // Async reset mid-EXEC at step 2, then restart with wait states
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 1,0,0,1,0,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 1,1,0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 1,0,1,2,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 0,0,0,3,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,0,0, 0,0,0,3,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0, 0,0,0,3,1,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0, 0,0,0,3,1,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,0, 0,0,0,3,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,0, 0,0,0,3,2,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    // Illegal at step 0 (with lastStep also high): trap, no retire, sticky until reset
    tbl.push_back(mk(0,1,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 1,1,0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 1,0,1,2,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,1,1,0, 0,0,0,3,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,1,0,0, 0,0,0,7,0,0,0,1,1,0));
    tbl.push_back(mk(0,0,1,0,0,1,0, 0,0,0,7,0,0,0,1,1,0));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Randomized programs, with a forced overflow, a full-length retire and an illegal trap.
    g_idle = 1'b1;
    gen_instr(MAXS + 1, 1'b0);
    gen_instr(MAXS, 1'b0);
    gen_instr(1, 1'b1);
    for (int p = 0; p < 60; p++) begin
      int sel = $urandom_range(0, 19);
      if (sel == 0)      gen_instr(1, 1'b1);
      else if (sel == 1) gen_instr(MAXS + 1, 1'b0);
      else               gen_instr($urandom_range(1, MAXS), 1'b0);
    end
    while (vq.size() > 0) apply(vq.pop_front());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised successor to the CPU's fixed 3-bit state counter. Sequences each instruction through fetch-low, fetch-high and a variable number of execute steps.
- Stalls on a memory ready/req handshake, ends an instruction early when the decoder flags its last step, and traps illegal or runaway instructions.
- Sits between the memory interface and the main/ALU decoders, which consume `phase` and `step`.

Parameters:
- STEP_WIDTH, 3, width of the execute-step counter.
- MAX_STEPS, 8, execute-step limit per instruction; must satisfy 2 <= MAX_STEPS <= 2**STEP_WIDTH.
- IRQ_STEPS, 2, length of the interrupt-entry sequence (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  when 0, sequencer parks in IDLE at the next instruction boundary
- memReq  in  1  decoder: the current execute step accesses memory
- memReady  in  1  memory: access completes this cycle
- lastStep  in  1  decoder: the current execute step is the final one
- illegal  in  1  decoder: opcode/func undefined; sampled at execute step 0
- fetchReq  out  1  instruction-byte read request (FETCH_LO/FETCH_HI)
- instrLowWriteEn  out  1  load the low instruction byte
- instrHighWriteEn  out  1  load the high instruction byte
- phase  out  3  current phase code
- step  out  STEP_WIDTH  execute-step index
- stall  out  1  step held waiting for memReady
- instrDone  out  1  one-cycle pulse on instruction retire
- fault  out  1  sticky trap flag
- faultCause  out  2  0 none, 1 illegal, 2 step overflow

Behaviour:
- Reset (asynchronous, any phase, mid-instruction included):
  - phase=IDLE, step=0, fault=0, faultCause=0.
  - All pulses/enables 0.
  - The first clock edge after deassert is evaluated from IDLE.
- Phases: IDLE=0, FETCH_LO=1, FETCH_HI=2, EXEC=3, IRQ=4, FAULT=7.
- IDLE:
  - run=1 -> FETCH_LO next cycle; otherwise stay.
  - All outputs 0.
- FETCH_LO:
  - fetchReq=1.
  - memReady=1 -> instrLowWriteEn=1 (combinational, same cycle), -> FETCH_HI.
  - memReady=0 -> stay; stall=1.
- FETCH_HI: same as FETCH_LO with instrHighWriteEn; -> EXEC with step=0.
- EXEC, priority in this order:
  1. step==0 && illegal -> FAULT, faultCause=1. No instrDone.
  2. memReq && !memReady -> hold step; stall=1.
  3. lastStep -> instrDone=1 this cycle; step<=0.
     - If run=1: -> FETCH_LO.
     - If run=0: -> IDLE.
  4. step==MAX_STEPS-1 -> FAULT, faultCause=2.
  5. Otherwise step<=step+1.
- Latency: instruction of N execute steps with zero wait states = 2+N cycles from FETCH_LO entry to instrDone. Each memReady=0 cycle adds one.
- lastStep with a memReq still pending waits for memReady before retiring.
- FAULT:
  - Terminal until reset; fault=1.
  - step frozen at the trapping value.
  - No fetchReq/enables.
- run dropping mid-instruction does not abort; it takes effect only at retire.
- memReady outside any request is ignored.
- Step counter never wraps: overflow is trapped before wrap.

Optional Feature:
- Macro SEQ_IRQ_EN.
- Defined:
  - Adds ports irq (in, level) and irqAck (out, 1-cycle pulse).
  - At retire, irq=1 takes priority over FETCH_LO/IDLE: -> IRQ phase, with step counting 0..IRQ_STEPS-1 (decoder drives vector/SP writes).
  - The memReq/memReady stall applies in IRQ as in EXEC.
  - irqAck pulses on the last IRQ step, then -> FETCH_LO; irq is not re-sampled until the next retire.
  - irq is ignored in IDLE, FETCH, and FAULT.
- Undefined: no irq/irqAck ports; phase code 4 is unreachable.

Decomposition:
- Package seq_pkg holds:
  - phase codes (localparam enum, 3-bit)
  - faultCause codes
  - default STEP_WIDTH/MAX_STEPS
- One sub-module: seq_step_counter. It holds the STEP_WIDTH counter with clear, hold and increment inputs and a terminal-count output (step==MAX_STEPS-1). The FSM stays in the top level.

Test Plan:
- Reset/boot: assert reset mid-EXEC at step=2 -> phase=0, step=0, fault=0 immediately. Deassert with run=1 -> phase=1 next cycle.
- 3-step instruction, memReady always 1, lastStep at step 2 -> instrLowWriteEn at cycle 0, instrHighWriteEn at cycle 1, steps 0,1,2, instrDone at cycle 4, phase=1 at cycle 5.
- Wait states: memReq at step 1 with memReady low for 3 cycles -> step held at 1, stall=1 for 3 cycles, retire delayed by 3.
- Illegal: illegal=1 at step 0 -> phase=7, faultCause=1, no instrDone. Further run/memReady toggles have no effect until reset.
- Overflow: MAX_STEPS=8, lastStep never asserted -> FAULT at step 7, faultCause=2.
- With SEQ_IRQ_EN: irq=1 during EXEC -> at retire phase=4, step 0..1, irqAck on step 1, then phase=1. Also drop run mid-instruction -> retire, then phase=0.
